// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-item vending machine.
// State encoding, coin values and the per-item price table live here.
package vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  localparam int COIN_VALUE_5  = 5;
  localparam int COIN_VALUE_10 = 10;

  localparam int PRICE_COUNT = 4;
  localparam int unsigned PRICE_TABLE [PRICE_COUNT] = '{15, 20, 25, 30};

  // Price of item idx; items beyond the table cost nothing (never sold).
  function automatic int unsigned price_of(input int unsigned idx);
    return (idx < PRICE_COUNT) ? PRICE_TABLE[idx[1:0]] : 0;
  endfunction

endpackage

// File: rtl/multi_vend_machine_if.sv
// Customer-side bus of the vending machine: coins, product selection,
// dispense/change pulses and status. Optional cancel input exists only
// when VEND_CANCEL_EN is defined.
// Handshake: fives/tens are sampled only when coin_valid is high; buy is a
// single-cycle request qualified by sel; vend_valid/change_valid/buy_err/
// coin_reject are one-cycle pulses with no back-pressure.
interface multi_vend_machine_if #(
  parameter int N_ITEMS  = 4,
  parameter int COIN_W   = 3,
  parameter int CREDIT_W = 8
);
  localparam int SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

  logic [COIN_W-1:0]   fives;
  logic [COIN_W-1:0]   tens;
  logic                coin_valid;
  logic [SEL_W-1:0]    sel;
  logic                buy;
`ifdef VEND_CANCEL_EN
  logic                cancel;
`endif
  logic                vend_valid;
  logic [SEL_W-1:0]    vend_item;
  logic [CREDIT_W-1:0] change;
  logic                change_valid;
  logic [CREDIT_W-1:0] credit;
  logic [N_ITEMS-1:0]  sold_out;
  logic                buy_err;
  logic                coin_reject;

  modport master (
`ifdef VEND_CANCEL_EN
    output cancel,
`endif
    output fives, tens, coin_valid, sel, buy,
    input  vend_valid, vend_item, change, change_valid, credit, sold_out,
    input  buy_err, coin_reject
  );

  modport slave (
`ifdef VEND_CANCEL_EN
    input  cancel,
`endif
    input  fives, tens, coin_valid, sel, buy,
    output vend_valid, vend_item, change, change_valid, credit, sold_out,
    output buy_err, coin_reject
  );
endinterface

// File: rtl/vend_stock.sv
// Per-item stock counters: loaded to STOCK_INIT on reset, decremented by
// one on each vend of that item, and flagged sold out at zero.
module vend_stock #(
  parameter int N_ITEMS    = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 2,
  parameter int SEL_W      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dec,
  input  logic [SEL_W-1:0]   dec_idx,
  output logic [N_ITEMS-1:0] sold_out
);
  logic [STOCK_W-1:0] stock [N_ITEMS];

  // Stock registers: reset load, saturating decrement on vend.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else if (dec && (stock[dec_idx] != '0)) begin
      stock[dec_idx] <= stock[dec_idx] - STOCK_W'(1);
    end
  end

  // Sold-out flags straight from the counters.
  always_comb begin
    sold_out = '0;
    for (int i = 0; i < N_ITEMS; i++) sold_out[i] = (stock[i] == '0);
  end
endmodule

// File: rtl/multi_vend_machine.sv
// Multi-item vending machine: accumulates 5/10 coins into credit, vends a
// selected item when credit and stock allow, then pays out the remainder.
// Optional feature macro: VEND_CANCEL_EN (adds a cancel/refund input).
module multi_vend_machine
  import vend_pkg::*;
#(
  parameter int N_ITEMS    = 4,
  parameter int COIN_W     = 3,
  parameter int CREDIT_W   = 8,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  multi_vend_machine_if.slave   bus,
  output state_t                fsm_state
);
  localparam int SEL_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int DEP_W      = CREDIT_W + 1;
  localparam int SUM_W      = CREDIT_W + 2;
  localparam int CREDIT_MAX = (1 << CREDIT_W) - 1;

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n;
  logic [SEL_W-1:0]    sel_q, sel_n;
  logic                buy_err_r, buy_err_n;
  logic                coin_reject_r, coin_reject_n;
  logic                stock_dec;
  logic [N_ITEMS-1:0]  stock_empty;

  logic [DEP_W-1:0]    deposit;
  logic [SUM_W-1:0]    sum;
  logic                fits;
  logic [CREDIT_W-1:0] price_sel, price_vend;
  logic                sel_ok, buy_ok, cancel_req;

  vend_stock #(
    .N_ITEMS(N_ITEMS), .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT), .SEL_W(SEL_W)
  ) u_stock (
    .clk(clk), .reset(reset), .dec(stock_dec), .dec_idx(sel_q), .sold_out(stock_empty)
  );

  // Selects past the last item are only possible when N_ITEMS is not a power of two.
  if ((1 << SEL_W) > N_ITEMS) begin : g_sel_range
    assign sel_ok = (32'(bus.sel) < 32'(N_ITEMS));
  end else begin : g_sel_full
    assign sel_ok = 1'b1;
  end

`ifdef VEND_CANCEL_EN
  assign cancel_req = (state == S_CREDIT) && bus.cancel;
`else
  assign cancel_req = 1'b0;
`endif

  // Deposit, overflow check and purchase qualification (pre-deposit credit).
  always_comb begin
    deposit    = DEP_W'(COIN_VALUE_5 * int'(bus.fives) + COIN_VALUE_10 * int'(bus.tens));
    sum        = SUM_W'(credit) + SUM_W'(deposit);
    fits       = (sum <= SUM_W'(CREDIT_MAX));
    price_sel  = CREDIT_W'(price_of(32'(bus.sel)));
    price_vend = CREDIT_W'(price_of(32'(sel_q)));
    buy_ok     = (state == S_CREDIT) && bus.buy && sel_ok &&
                 (credit >= price_sel) && !stock_empty[bus.sel];
  end

  // Next-state, next-credit and error-pulse logic.
  always_comb begin
    state_n       = state;
    credit_n      = credit;
    sel_n         = sel_q;
    buy_err_n     = 1'b0;
    coin_reject_n = 1'b0;
    stock_dec     = 1'b0;
    case (state)
      S_IDLE, S_CREDIT: begin
        if (cancel_req) begin
          // Refund wins over buy; coins arriving now cannot join the refund.
          state_n       = S_CHANGE;
          coin_reject_n = bus.coin_valid;
        end else if (buy_ok) begin
          state_n       = S_VEND;
          sel_n         = bus.sel;
          coin_reject_n = bus.coin_valid;
        end else begin
          buy_err_n = bus.buy;
          if (bus.coin_valid) begin
            if (fits) begin
              credit_n = CREDIT_W'(sum);
              if (sum != '0) state_n = S_CREDIT;
            end else begin
              coin_reject_n = 1'b1;
            end
          end
        end
      end
      S_VEND: begin
        stock_dec     = 1'b1;
        credit_n      = credit - price_vend;
        state_n       = (credit != price_vend) ? S_CHANGE : S_IDLE;
        coin_reject_n = bus.coin_valid;
      end
      S_CHANGE: begin
        credit_n      = '0;
        state_n       = S_IDLE;
        coin_reject_n = bus.coin_valid;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, credit, latched selection and error pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      credit        <= '0;
      sel_q         <= '0;
      buy_err_r     <= 1'b0;
      coin_reject_r <= 1'b0;
    end else begin
      state         <= state_n;
      credit        <= credit_n;
      sel_q         <= sel_n;
      buy_err_r     <= buy_err_n;
      coin_reject_r <= coin_reject_n;
    end
  end

  assign bus.vend_valid   = (state == S_VEND);
  assign bus.vend_item    = (state == S_VEND) ? sel_q : '0;
  assign bus.change_valid = (state == S_CHANGE);
  assign bus.change       = (state == S_CHANGE) ? credit : '0;
  assign bus.credit       = credit;
  assign bus.sold_out     = stock_empty;
  assign bus.buy_err      = buy_err_r;
  assign bus.coin_reject  = coin_reject_r;
  assign fsm_state        = state;
endmodule

// File: doc/multi_vend_machine.md
MULTI_VEND_MACHINE -- requirements
Module: multi_vend_machine

Interface
REQ-001 SHALL have parameter N_ITEMS, default 4: number of products; SEL_W = clog2(N_ITEMS).
REQ-002 SHALL have parameter COIN_W, default 3: width of per-cycle coin counts.
REQ-003 SHALL have parameter CREDIT_W, default 8: credit and change width; CREDIT_MAX = 2^CREDIT_W-1.
REQ-004 SHALL have parameter STOCK_W, default 4: per-item stock counter width.
REQ-005 SHALL have parameter STOCK_INIT, default 2: stock of every item after reset.
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port fives, input, COIN_W: number of 5-unit coins inserted this cycle.
REQ-009 SHALL have port tens, input, COIN_W: number of 10-unit coins inserted this cycle.
REQ-010 SHALL have port coin_valid, input, 1: fives/tens qualify this cycle.
REQ-011 SHALL have port sel, input, SEL_W: product select.
REQ-012 SHALL have port buy, input, 1: purchase request for sel.
REQ-013 SHALL have port vend_valid, output, 1: one-cycle dispense pulse.
REQ-014 SHALL have port vend_item, output, SEL_W: dispensed item id, valid with vend_valid.
REQ-015 SHALL have port change, output, CREDIT_W: change amount, valid with change_valid, else 0.
REQ-016 SHALL have port change_valid, output, 1: one-cycle change pulse.
REQ-017 SHALL have port credit, output, CREDIT_W: current registered credit.
REQ-018 SHALL have port sold_out, output, N_ITEMS: bit i = stock[i]==0.
REQ-019 SHALL have ports buy_err and coin_reject, output, 1 each: one-cycle error pulses.

Function
REQ-020 SHALL implement FSM IDLE, CREDIT, VEND, CHANGE.
REQ-021 SHALL compute deposit = 5*fives + 10*tens in CREDIT_W+1 bits.
REQ-022 SHALL, in IDLE/CREDIT with coin_valid, add deposit to credit when credit+deposit <= CREDIT_MAX; IDLE->CREDIT if the result is nonzero.
REQ-023 SHALL reject the whole deposit on overflow: credit unchanged, coin_reject pulses the next cycle.
REQ-024 SHALL reject coins (coin_reject) when coin_valid arrives in VEND, in CHANGE, or in the same cycle as an accepted buy.
REQ-025 SHALL accept buy in CREDIT when credit >= PRICE_TABLE[sel] and stock[sel] != 0, using the pre-deposit credit; next state VEND.
REQ-026 SHALL, on a rejected buy (insufficient credit, sold out, IDLE, or sel >= N_ITEMS), pulse buy_err the next cycle, leave credit unchanged, and stay in state.
REQ-027 SHALL, in VEND, assert vend_valid=1 and vend_item=latched sel for one cycle, decrement stock, and subtract the price from credit.
REQ-028 SHALL go VEND->CHANGE if the remaining credit > 0, else VEND->IDLE.
REQ-029 SHALL, in CHANGE, assert change=credit and change_valid for one cycle, clear credit, then go to IDLE.
REQ-030 SHALL meet this latency: buy accepted at edge N -> vend_valid in cycle N+1 -> change_valid in cycle N+2.
REQ-031 SHALL ignore buy in VEND/CHANGE without buy_err; the machine is busy.

Reset
REQ-032 SHALL, on asserted reset (low), immediately force state IDLE, credit 0, all stocks STOCK_INIT, and all pulse outputs, change and vend_item to 0, independent of clk.
REQ-033 SHALL, on reset during VEND/CHANGE, abort: no vend_valid/change_valid pulse, credit lost, stock restored to STOCK_INIT.

Configuration
REQ-034 SHALL, with VEND_CANCEL_EN defined, provide input cancel (1 bit): in CREDIT, cancel -> CHANGE refunding full credit; cancel has priority over buy (buy dropped, no buy_err); cancel in other states is ignored.
REQ-035 SHALL, without VEND_CANCEL_EN, omit the cancel port and cancel logic; credit is returned only as change after a vend.

Structure
REQ-036 SHALL place state enum, PRICE_TABLE (default {15,20,25,30}, indexed by item), and coin values 5/10 in package vend_pkg.
REQ-037 SHALL implement per-item stock counters in sub-module vend_stock (decrement-on-vend, sold_out flags, reset load).

Verification
REQ-038 SHALL verify: reset low then high -> credit=0, sold_out=0000, state IDLE, no pulses.
REQ-039 SHALL verify: fives=2, tens=2, coin_valid 1 cycle -> credit=30; buy sel=0 -> vend_valid, vend_item=0 next cycle; change=15, change_valid next; credit=0.
REQ-040 SHALL verify: credit=10, buy sel=3 -> buy_err pulse, credit=10, state CREDIT.
REQ-041 SHALL verify: two exact-20 purchases of item 1 -> sold_out[1]=1; third buy sel=1 with credit 20 -> buy_err.
REQ-042 SHALL verify: credit=250, tens=1 coin_valid -> coin_reject, credit=250; buy + coin same cycle -> coin_reject.
REQ-043 SHALL verify, with VEND_CANCEL_EN: credit=35, cancel and buy together -> change=35 next cycle, no vend_valid, credit=0.
